// File: rtl/rom_arbiter_if.sv
// Bus bundle for rom_arbiter: two requester ports, a shared response and the ROM read port.
interface rom_arbiter_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
);
    logic              ReqValid0;
    logic              ReqValid1;
    logic [ADDR_W-1:0] ReqAddr0;
    logic [ADDR_W-1:0] ReqAddr1;
    logic              ReqReady0;
    logic              ReqReady1;
    logic              RespValid0;
    logic              RespValid1;
    logic [31:0]       RespData;
    logic              RespErr;
    logic [ADDR_W-1:0] RomAddrOut;
    logic [DATA_W-1:0] RomDataIn;
    logic              RomReadyIn;
    logic              Busy;

    // Arbiter side
    modport slave (
        input  ReqValid0, ReqValid1, ReqAddr0, ReqAddr1, RomDataIn, RomReadyIn,
        output ReqReady0, ReqReady1, RespValid0, RespValid1, RespData, RespErr,
        output RomAddrOut, Busy
    );

    // Requester / ROM side
    modport master (
        output ReqValid0, ReqValid1, ReqAddr0, ReqAddr1, RomDataIn, RomReadyIn,
        input  ReqReady0, ReqReady1, RespValid0, RespValid1, RespData, RespErr,
        input  RomAddrOut, Busy
    );
endinterface

// File: rtl/rom_arbiter.sv
// Two-port round-robin arbiter in front of a single-word ROM read port, with address
// range checking and a WAIT timeout that turns a silent ROM into an error response.
module rom_arbiter #(
    parameter int unsigned       ADDR_W   = 64,
    parameter int unsigned       DATA_W   = 64,
    parameter int unsigned       TIMEOUT  = 8,
    parameter logic [ADDR_W-1:0] ROM_BASE = 64'h8000_0000,
    parameter logic [ADDR_W-1:0] ROM_LAST = 64'h8FFF_FFFC
) (
    input logic          Clk,
    input logic          Rst,
    rom_arbiter_if.slave bus
);
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e            state_q, state_d;
    logic              last_q, last_d;      // last granted port
    logic              port_q, port_d;      // port owning the current access
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;  // doubles as the latched request address
    logic              resp_valid0_q, resp_valid0_d;
    logic              resp_valid1_q, resp_valid1_d;
    logic [31:0]       resp_data_q, resp_data_d;
    logic              resp_err_q, resp_err_d;
    logic              busy_q, busy_d;

    logic              gnt1;
    logic              accept;
    logic [ADDR_W-1:0] req_addr;

    function automatic logic is_legal(input logic [ADDR_W-1:0] a);
        return (a[1:0] == 2'b00) && (a >= ROM_BASE) && (a <= ROM_LAST);
    endfunction

    // Round-robin grant: with both valid, the port not granted last wins
    always_comb begin
        gnt1     = bus.ReqValid1 & (~bus.ReqValid0 | ~last_q);
        accept   = Rst & (state_q == StIdle) & (bus.ReqValid0 | bus.ReqValid1);
        req_addr = gnt1 ? bus.ReqAddr1 : bus.ReqAddr0;
    end

    // Handshake is combinational; held low while reset is asserted
    assign bus.ReqReady0 = accept & ~gnt1;
    assign bus.ReqReady1 = accept & gnt1;

    // Next-state and registered-output computation
    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        port_d        = port_q;
        cnt_d         = cnt_q;
        rom_addr_d    = rom_addr_q;
        resp_valid0_d = 1'b0;
        resp_valid1_d = 1'b0;
        resp_data_d   = resp_data_q;
        resp_err_d    = resp_err_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    last_d = gnt1;
                    port_d = gnt1;
                    if (is_legal(req_addr)) begin
                        state_d    = StIssue;
                        rom_addr_d = req_addr;
                    end else begin
                        // Illegal: answer next cycle without touching the ROM
                        state_d       = StResp;
                        resp_data_d   = '0;
                        resp_err_d    = 1'b1;
                        resp_valid0_d = ~gnt1;
                        resp_valid1_d = gnt1;
                    end
                end
            end
            StIssue: begin
                state_d = StWait;
                cnt_d   = '0;
            end
            StWait: begin
                if (bus.RomReadyIn) begin
                    state_d       = StResp;
                    rom_addr_d    = '0;
                    resp_data_d   = bus.RomDataIn[31:0];
                    resp_err_d    = 1'b0;
                    resp_valid0_d = ~port_q;
                    resp_valid1_d = port_q;
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    state_d       = StResp;
                    rom_addr_d    = '0;
                    resp_data_d   = '0;
                    resp_err_d    = 1'b1;
                    resp_valid0_d = ~port_q;
                    resp_valid1_d = port_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    // State and output registers; reset aborts any access in flight
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q       <= StIdle;
            last_q        <= 1'b1;
            port_q        <= 1'b0;
            cnt_q         <= '0;
            rom_addr_q    <= '0;
            resp_valid0_q <= 1'b0;
            resp_valid1_q <= 1'b0;
            resp_data_q   <= '0;
            resp_err_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            port_q        <= port_d;
            cnt_q         <= cnt_d;
            rom_addr_q    <= rom_addr_d;
            resp_valid0_q <= resp_valid0_d;
            resp_valid1_q <= resp_valid1_d;
            resp_data_q   <= resp_data_d;
            resp_err_q    <= resp_err_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.RomAddrOut = rom_addr_q;
    assign bus.RespValid0 = resp_valid0_q;
    assign bus.RespValid1 = resp_valid1_q;
    assign bus.RespData   = resp_data_q;
    assign bus.RespErr    = resp_err_q;
    assign bus.Busy       = busy_q;

    // Only the low word of the ROM bus carries an instruction
    if (DATA_W > 32) begin : g_rom_hi
        logic unused_rom_hi;
        assign unused_rom_hi = ^bus.RomDataIn[DATA_W-1:32];
    end
endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: vector table plus round-robin and reset-abort sequences.
module tb_rom_arbiter;
    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;

    logic Clk = 1'b0;
    logic Rst = 1'b0;
    always #5 Clk = ~Clk;

    rom_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    rom_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (8),
        .ROM_BASE(64'h8000_0000),
        .ROM_LAST(64'h8FFF_FFFC)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .bus(bus)
    );

    // ROM model: answers whenever an address is presented, unless disabled
    logic        rom_en;
    logic [31:0] rom_word;
    assign bus.RomReadyIn = rom_en && (bus.RomAddrOut != '0);
    assign bus.RomDataIn  = {32'hDEAD_BEEF, rom_word};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    typedef struct {
        logic        v0;
        logic        v1;
        logic [63:0] a0;
        logic [63:0] a1;
        logic        rom_en;
        logic [31:0] word;
        int          exp_port;
        int          exp_lat;
        logic        exp_err;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[10];

    task automatic run_vec(input vec_t v, input int idx);
        int          waited;
        int          lat;
        logic [63:0] exp_rom;
        bus.ReqValid0 = v.v0;
        bus.ReqValid1 = v.v1;
        bus.ReqAddr0  = v.a0;
        bus.ReqAddr1  = v.a1;
        rom_en        = v.rom_en;
        rom_word      = v.word;
        #1;
        waited = 0;
        while (!(bus.ReqReady0 || bus.ReqReady1) && waited < 8) begin
            tick();
            waited++;
        end
        check($sformatf("v%0d accept", idx), 64'(bus.ReqReady0 | bus.ReqReady1), 64'd1);
        check($sformatf("v%0d grant", idx), 64'({bus.ReqReady1, bus.ReqReady0}),
              (v.exp_port == 1) ? 64'd2 : 64'd1);
        exp_rom = (v.exp_lat > 1) ? ((v.exp_port == 1) ? v.a1 : v.a0) : 64'd0;
        tick();
        bus.ReqValid0 = 1'b0;
        bus.ReqValid1 = 1'b0;
        lat = 1;
        while (!(bus.RespValid0 || bus.RespValid1) && lat < 16) begin
            check($sformatf("v%0d rom_addr c%0d", idx, lat), bus.RomAddrOut, exp_rom);
            tick();
            lat++;
        end
        check($sformatf("v%0d latency", idx), 64'(lat), 64'(v.exp_lat));
        check($sformatf("v%0d resp_port", idx), 64'({bus.RespValid1, bus.RespValid0}),
              (v.exp_port == 1) ? 64'd2 : 64'd1);
        check($sformatf("v%0d resp_data", idx), 64'(bus.RespData), 64'(v.exp_data));
        check($sformatf("v%0d resp_err", idx), 64'(bus.RespErr), 64'(v.exp_err));
        check($sformatf("v%0d rom_addr resp", idx), bus.RomAddrOut, 64'd0);
        tick();
        check($sformatf("v%0d pulse end", idx), 64'({bus.RespValid1, bus.RespValid0}), 64'd0);
        check($sformatf("v%0d data hold", idx), 64'(bus.RespData), 64'(v.exp_data));
        check($sformatf("v%0d idle busy", idx), 64'(bus.Busy), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_rr;
        int         seen;

        //           v0    v1    a0             a1             en    word           port lat err data
        vecs[0] = '{1'b1, 1'b0, 64'h8000_0000, 64'h0,         1'b1, 32'h0000_0013, 0, 3,  1'b0, 32'h0000_0013};
        vecs[1] = '{1'b0, 1'b1, 64'h0,         64'h8000_0004, 1'b1, 32'hCAFE_0001, 1, 3,  1'b0, 32'hCAFE_0001};
        vecs[2] = '{1'b1, 1'b1, 64'h8000_0010, 64'h8000_0020, 1'b1, 32'h1111_2222, 0, 3,  1'b0, 32'h1111_2222};
        vecs[3] = '{1'b1, 1'b1, 64'h8000_0010, 64'h8000_0020, 1'b1, 32'h3333_4444, 1, 3,  1'b0, 32'h3333_4444};
        vecs[4] = '{1'b0, 1'b1, 64'h0,         64'h0000_0000, 1'b1, 32'h7777_7777, 1, 1,  1'b1, 32'h0};
        vecs[5] = '{1'b0, 1'b1, 64'h0,         64'h8000_0002, 1'b1, 32'h7777_7777, 1, 1,  1'b1, 32'h0};
        vecs[6] = '{1'b0, 1'b1, 64'h0,         64'h9000_0000, 1'b1, 32'h7777_7777, 1, 1,  1'b1, 32'h0};
        vecs[7] = '{1'b1, 1'b0, 64'h8FFF_FFFC, 64'h0,         1'b1, 32'h5555_AAAA, 0, 3,  1'b0, 32'h5555_AAAA};
        vecs[8] = '{1'b1, 1'b0, 64'h7FFF_FFFC, 64'h0,         1'b1, 32'h7777_7777, 0, 1,  1'b1, 32'h0};
        vecs[9] = '{1'b1, 1'b0, 64'h8000_0100, 64'h0,         1'b0, 32'h7777_7777, 0, 10, 1'b1, 32'h0};

        // Reset state, with a request pending to show ReqReady stays low
        bus.ReqValid0 = 1'b1;
        bus.ReqValid1 = 1'b1;
        bus.ReqAddr0  = 64'h8000_0000;
        bus.ReqAddr1  = 64'h8000_0000;
        rom_en        = 1'b1;
        rom_word      = 32'h0;
        #12;
        check("reset ready", 64'({bus.ReqReady1, bus.ReqReady0}), 64'd0);
        check("reset resp", 64'({bus.RespValid1, bus.RespValid0, bus.RespErr}), 64'd0);
        check("reset data", 64'(bus.RespData), 64'd0);
        check("reset rom_addr", bus.RomAddrOut, 64'd0);
        check("reset busy", 64'(bus.Busy), 64'd0);
        bus.ReqValid0 = 1'b0;
        bus.ReqValid1 = 1'b0;
        Rst = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], i);
        end

        // Round-robin with both ports streaming: accepts every 4 cycles, alternating
        Rst = 1'b0;
        tick();
        Rst = 1'b1;
        tick();
        bus.ReqValid0 = 1'b1;
        bus.ReqValid1 = 1'b1;
        bus.ReqAddr0  = 64'h8000_0040;
        bus.ReqAddr1  = 64'h8000_0080;
        rom_en        = 1'b1;
        rom_word      = 32'h0000_0013;
        #1;
        for (int c = 0; c < 16; c++) begin
            exp_rr = {(c % 8 == 0), (c % 8 == 4), (c % 8 == 3), (c % 8 == 7)};
            check($sformatf("rr c%0d {rdy0,rdy1,rv0,rv1}", c),
                  64'({bus.ReqReady0, bus.ReqReady1, bus.RespValid0, bus.RespValid1}),
                  64'(exp_rr));
            tick();
        end
        bus.ReqValid0 = 1'b0;
        bus.ReqValid1 = 1'b0;
        tick();

        // Reset asserted mid-WAIT: immediate reset values, no response afterwards
        bus.ReqValid0 = 1'b1;
        bus.ReqAddr0  = 64'h8000_0200;
        rom_en        = 1'b0;
        #1;
        check("abort accept", 64'(bus.ReqReady0), 64'd1);
        tick();
        tick();
        tick();
        check("abort busy before", 64'(bus.Busy), 64'd1);
        check("abort rom_addr before", bus.RomAddrOut, 64'h8000_0200);
        Rst = 1'b0;
        #1;
        check("abort ready", 64'({bus.ReqReady1, bus.ReqReady0}), 64'd0);
        check("abort resp", 64'({bus.RespValid1, bus.RespValid0, bus.RespErr}), 64'd0);
        check("abort data", 64'(bus.RespData), 64'd0);
        check("abort rom_addr", bus.RomAddrOut, 64'd0);
        check("abort busy", 64'(bus.Busy), 64'd0);
        bus.ReqValid0 = 1'b0;
        tick();
        tick();
        Rst    = 1'b1;
        rom_en = 1'b1;
        seen   = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (bus.RespValid0 || bus.RespValid1 || bus.Busy) seen++;
        end
        check("abort no late resp", 64'(seen), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
